// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Multi-port register file with write-to-read bypass and a
//            per-register pending-write scoreboard (RAW busy, issue stall).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int PEND_W   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  flush_n,
    input  logic                  pipe_flush_i,
    input  logic [NRD*AW-1:0]     rd_addr_i,
    output logic [NRD*DATA_W-1:0] rd_data_o,
    output logic [NRD-1:0]        rd_busy_o,
    input  logic [NWR-1:0]        wr_en_i,
    input  logic [NWR*AW-1:0]     wr_addr_i,
    input  logic [NWR*DATA_W-1:0] wr_data_i,
    input  logic [NWR-1:0]        wr_retire_i,
    input  logic                  issue_valid_i,
    input  logic                  issue_wr_i,
    input  logic [AW-1:0]         issue_dest_i,
    output logic                  issue_ready_o,
    output logic                  sb_err_o
);

    // Wide enough to hold pend + 1 and the retire count without wrapping.
    localparam int CW = PEND_W + $clog2(NWR + 1) + 1;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [PEND_W-1:0] pend_q [NREGS];
    logic [PEND_W-1:0] pend_d [NREGS];
    logic [CW-1:0]     dec    [NREGS];
    logic              sb_err_q;
    logic              sb_err_d;
    logic              issue_acc;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Retiring writes this cycle, counted per destination register.
    always_comb begin
        for (int r = 0; r < NREGS; r++) dec[r] = '0;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j] && wr_retire_i[j])
                dec[wr_addr_i[j*AW +: AW]] = dec[wr_addr_i[j*AW +: AW]] + CW'(1);
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]     rd_a;
        logic [DATA_W-1:0] rd_val;

        assign rd_a = rd_addr_i[i*AW +: AW];

        always_comb begin
            rd_val = regs_q[rd_a];
            for (int j = 0; j < NWR; j++) begin
                if (wr_en_i[j] && (wr_addr_i[j*AW +: AW] == rd_a))
                    rd_val = wr_data_i[j*DATA_W +: DATA_W];
            end
            if (is_zero(rd_a)) rd_val = '0;
        end

        assign rd_data_o[i*DATA_W +: DATA_W] = rd_val;
        assign rd_busy_o[i] = {{(CW-PEND_W){1'b0}}, pend_q[rd_a]} > dec[rd_a];
    end

    assign issue_ready_o = !(issue_wr_i && (pend_q[issue_dest_i] == PEND_MAX)
                             && (dec[issue_dest_i] == '0));
    assign issue_acc     = issue_valid_i && issue_ready_o && issue_wr_i
                           && !is_zero(issue_dest_i) && !pipe_flush_i;

    always_comb begin
        regs_d   = regs_q;
        sb_err_d = sb_err_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en_i[j] && !is_zero(wr_addr_i[j*AW +: AW]))
                regs_d[wr_addr_i[j*AW +: AW]] = wr_data_i[j*DATA_W +: DATA_W];
        end
        for (int r = 0; r < NREGS; r++) begin
            if (pipe_flush_i || ((ZERO_REG != 0) && (r == 0))) begin
                pend_d[r] = '0;
            end else if (dec[r] > ({{(CW-PEND_W){1'b0}}, pend_q[r]}
                         + {{(CW-1){1'b0}}, (issue_acc && (issue_dest_i == AW'(r)))})) begin
                pend_d[r] = '0;
                sb_err_d  = 1'b1;
            end else begin
                pend_d[r] = PEND_W'({{(CW-PEND_W){1'b0}}, pend_q[r]}
                          + {{(CW-1){1'b0}}, (issue_acc && (issue_dest_i == AW'(r)))}
                          - dec[r]);
            end
        end
    end

    always_ff @(posedge clk or negedge flush_n) begin
        if (!flush_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
            sb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            pend_q   <= pend_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err_o = sb_err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// Self-checking bench for regfile_scoreboard: reference model compared every
// cycle plus directed literal expectations.
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          flush_n = 1'b0;
    logic          pipe_flush = 1'b0;
    logic [2*AW-1:0] rd_addr = '0;
    logic [2*DW-1:0] rd_data;
    logic [1:0]    rd_busy;
    logic [1:0]    wr_en = '0;
    logic [2*AW-1:0] wr_addr = '0;
    logic [2*DW-1:0] wr_data = '0;
    logic [1:0]    wr_retire = '0;
    logic          issue_valid = 1'b0;
    logic          issue_wr = 1'b0;
    logic [AW-1:0] issue_dest = '0;
    logic          issue_ready;
    logic          sb_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mregs [32];
    int            mpend [32];
    bit            merr;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk          (clk),
        .flush_n      (flush_n),
        .pipe_flush_i (pipe_flush),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .rd_busy_o    (rd_busy),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .wr_retire_i  (wr_retire),
        .issue_valid_i(issue_valid),
        .issue_wr_i   (issue_wr),
        .issue_dest_i (issue_dest),
        .issue_ready_o(issue_ready),
        .sb_err_o     (sb_err)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int m_ret(input int a);
        int n = 0;
        for (int j = 0; j < 2; j++)
            if (wr_en[j] && wr_retire[j] && (int'(wr_addr[j*AW +: AW]) == a)) n++;
        return n;
    endfunction

    function automatic logic [DW-1:0] m_rd(input int a);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        v = mregs[a];
        for (int j = 0; j < 2; j++)
            if (wr_en[j] && (int'(wr_addr[j*AW +: AW]) == a)) v = wr_data[j*DW +: DW];
        return v;
    endfunction

    function automatic bit m_ready();
        int d = int'(issue_dest);
        return !(issue_wr && d != 0 && mpend[d] == 3 && m_ret(d) == 0);
    endfunction

    // Reference model state update.
    always @(posedge clk or negedge flush_n) begin
        if (!flush_n) begin
            for (int r = 0; r < 32; r++) begin
                mregs[r] = '0;
                mpend[r] = 0;
            end
            merr = 1'b0;
        end else begin
            bit acc;
            acc = issue_valid && issue_wr && m_ready() && !pipe_flush;
            for (int r = 1; r < 32; r++) begin
                int sum, d;
                if (pipe_flush) begin
                    mpend[r] = 0;
                end else begin
                    sum = mpend[r] + ((acc && int'(issue_dest) == r) ? 1 : 0);
                    d   = m_ret(r);
                    if (d > sum) begin
                        mpend[r] = 0;
                        merr = 1'b1;
                    end else begin
                        mpend[r] = sum - d;
                    end
                end
            end
            for (int j = 0; j < 2; j++)
                if (wr_en[j] && wr_addr[j*AW +: AW] != 0)
                    mregs[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int a;
            a = int'(rd_addr[i*AW +: AW]);
            chk($sformatf("model_rd_data%0d", i), 64'(rd_data[i*DW +: DW]), 64'(m_rd(a)));
            chk($sformatf("model_rd_busy%0d", i), 64'(rd_busy[i]),
                64'((a != 0) && (mpend[a] > m_ret(a))));
        end
        chk("model_issue_ready", 64'(issue_ready), 64'(m_ready()));
        chk("model_sb_err", 64'(sb_err), 64'(merr));
    end

    task automatic idle();
        pipe_flush  = 1'b0;
        wr_en       = '0;
        wr_retire   = '0;
        wr_addr     = '0;
        wr_data     = '0;
        issue_valid = 1'b0;
        issue_wr    = 1'b0;
        issue_dest  = '0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        // Reset state
        idle();
        @(negedge clk);
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);
        chk("rst_sb_err", 64'(sb_err), 64'd0);
        next_cyc();
        flush_n = 1'b1;
        for (int r = 0; r < 32; r++) begin
            rd_addr = {5'(r), 5'(r)};
            @(negedge clk);
            chk("rst_rd_data", 64'(rd_data), 64'd0);
            chk("rst_rd_busy", 64'(rd_busy), 64'd0);
            next_cyc();
        end

        // Bypass and stored read of r5, r0 writes dropped
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'hDEADBEEF};
        rd_addr = {5'd5, 5'd0};
        @(negedge clk);
        chk("bypass_r5", 64'(rd_data[63:32]), 64'hDEADBEEF);
        next_cyc();
        rd_addr = {5'd0, 5'd5};
        @(negedge clk);
        chk("stored_r5", 64'(rd_data[31:0]), 64'hDEADBEEF);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'd0, 32'h1234};
        rd_addr = {5'd0, 5'd0};
        @(negedge clk);
        chk("bypass_r0", 64'(rd_data), 64'd0);
        next_cyc();
        rd_addr = {5'd0, 5'd0};
        @(negedge clk);
        chk("stored_r0", 64'(rd_data), 64'd0);

        // Same-address writes: highest port wins
        next_cyc();
        wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
        rd_addr = {5'd0, 5'd7};
        @(negedge clk);
        chk("bypass_r7", 64'(rd_data[31:0]), 64'h22);
        next_cyc();
        rd_addr = {5'd7, 5'd7};
        @(negedge clk);
        chk("stored_r7", 64'(rd_data[63:32]), 64'h22);

        // Scoreboard saturation on r3
        for (int k = 0; k < 3; k++) begin
            next_cyc();
            issue_valid = 1'b1; issue_wr = 1'b1; issue_dest = 5'd3;
            rd_addr = {5'd0, 5'd3};
        end
        next_cyc();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_dest = 5'd3; rd_addr = {5'd0, 5'd3};
        @(negedge clk);
        chk("sat_ready", 64'(issue_ready), 64'd0);
        chk("sat_busy", 64'(rd_busy[0]), 64'd1);
        next_cyc();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_dest = 5'd3; rd_addr = {5'd0, 5'd3};
        wr_en = 2'b01; wr_retire = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'hA};
        @(negedge clk);
        chk("sat_retire_ready", 64'(issue_ready), 64'd1);
        next_cyc();
        issue_wr = 1'b1; issue_dest = 5'd3; rd_addr = {5'd0, 5'd3};
        @(negedge clk);
        chk("count_stays_3", 64'(issue_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            next_cyc();
            rd_addr = {5'd0, 5'd3};
            wr_en = 2'b10; wr_retire = 2'b10; wr_addr = {5'd3, 5'd0};
            wr_data = {32'(k + 1), 32'd0};
            @(negedge clk);
            chk("retire_busy", 64'(rd_busy[0]), (k == 2) ? 64'd0 : 64'd1);
            if (k == 2) chk("retire_bypass", 64'(rd_data[31:0]), 64'd3);
        end

        // Pipe flush discards pending and same-cycle issue
        next_cyc();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_dest = 5'd9;
        next_cyc();
        pipe_flush = 1'b1; issue_valid = 1'b1; issue_wr = 1'b1; issue_dest = 5'd9;
        rd_addr = {5'd9, 5'd0};
        @(negedge clk);
        chk("preflush_busy", 64'(rd_busy[1]), 64'd1);
        next_cyc();
        rd_addr = {5'd9, 5'd0};
        @(negedge clk);
        chk("postflush_busy", 64'(rd_busy[1]), 64'd0);

        // Retire underflow sets sticky error, async reset clears all
        next_cyc();
        wr_en = 2'b01; wr_retire = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'd0, 32'h44};
        next_cyc();
        @(negedge clk);
        chk("sb_err_set", 64'(sb_err), 64'd1);
        next_cyc();
        issue_valid = 1'b1; issue_wr = 1'b1; issue_dest = 5'd3;
        @(negedge clk);
        chk("sb_err_sticky", 64'(sb_err), 64'd1);
        next_cyc();
        rd_addr = {5'd3, 5'd5};
        #2;
        flush_n = 1'b0;
        #1;
        chk("arst_rd_data", 64'(rd_data), 64'd0);
        chk("arst_rd_busy", 64'(rd_busy), 64'd0);
        chk("arst_ready", 64'(issue_ready), 64'd1);
        chk("arst_sb_err", 64'(sb_err), 64'd0);
        next_cyc();
        next_cyc();
        flush_n = 1'b1;

        // Mixed traffic checked by the model
        for (int k = 0; k < 60; k++) begin
            next_cyc();
            wr_en       = 2'($urandom);
            wr_retire   = 2'($urandom);
            wr_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wr_data     = {32'($urandom), 32'($urandom)};
            issue_valid = 1'($urandom);
            issue_wr    = 1'($urandom);
            issue_dest  = 5'($urandom_range(0, 7));
            rd_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
        end
        next_cyc();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the decode-stage register file.
- Adds configurable data width, register count and read/write port counts, plus write-to-read bypass.
- Adds a per-register pending-write scoreboard that raises read-busy (RAW hazard) and issue back-pressure.
- Sits in the decode stage: decode queries it at issue, and the writeback/load-return paths write and retire through it.

Parameters:
DATA_W, 32, data width of each register
NREGS, 32, number of architectural registers (power of two); AW = log2(NREGS)
NRD, 2, number of combinational read ports
NWR, 2, number of write ports (e.g. ALU result, late load return)
PEND_W, 2, width of per-register pending-write counter; max outstanding = 2^PEND_W-1
ZERO_REG, 1, 1 = register 0 hardwired to zero and never tracked

Ports:
clk  in  1  clock, all state on rising edge
flush_n  in  1  asynchronous active-low reset
pipe_flush  in  1  synchronous: clear all pending counters; register contents kept
rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_data  out  NRD*DATA_W  read data, port i
rd_busy  out  NRD  port i register has an unretired pending write not satisfied this cycle
wr_en  in  NWR  write enable per port
wr_addr  in  NWR*AW  write address per port
wr_data  in  NWR*DATA_W  write data per port
wr_retire  in  NWR  write also retires one pending entry for wr_addr (ignored unless wr_en)
issue_valid  in  1  decode issues an instruction this cycle
issue_wr  in  1  issued instruction will write issue_dest
issue_dest  in  AW  destination register of issued instruction
issue_ready  out  1  issue may be accepted this cycle
sb_err  out  1  sticky: retire seen on a register with zero pending count

Behaviour:
- Reset (flush_n low, async): all registers, all pending counters and sb_err = 0. Outputs follow: rd_data = 0, rd_busy = 0, issue_ready = 1.
- Reads are combinational. rd_data[i] = 0 if ZERO_REG and rd_addr[i] == 0.
- Otherwise, bypass: if any wr_en[j] with wr_addr[j] == rd_addr[i] this cycle, rd_data[i] = wr_data of the highest-index such j. Else the stored value.
- Writes land on the rising edge. Same-address writes on several ports in one cycle: the highest-index port wins. Writes to reg 0 are dropped when ZERO_REG = 1.
- Issue is accepted when issue_valid & issue_ready.
- issue_ready = 0 iff issue_wr and pend[issue_dest] == 2^PEND_W-1 and no retire to issue_dest this cycle. issue_ready is combinational and does not depend on issue_valid.
- Counter update per register r, evaluated each edge:
  - inc = accepted issue with issue_wr and issue_dest == r.
  - dec = number of ports j with wr_en[j] & wr_retire[j] & wr_addr[j] == r.
  - pend_next = pend + inc - dec, clamped at 0.
  - If dec > pend + inc, pend_next = 0 and sb_err is set (sticky until reset).
  - Simultaneous issue and retire to the same r: net change 0.
  - r = 0 with ZERO_REG = 1 is never counted and never busy.
- rd_busy[i] = (pend[rd_addr[i]] > retires to rd_addr[i] this cycle). A final retiring write this cycle therefore clears busy combinationally, consistent with the bypass.
- pipe_flush: on the edge, all pend = 0. A same-cycle issue is discarded, and writes still update registers. sb_err is not cleared.
- pipe_flush has priority over issue and retire for counter state.
- No stall input: the caller gates wr_en during stalls.
- Latency: read 0 cycles, write visible to stored-path reads next cycle (same cycle via bypass), scoreboard 1 cycle.

Test Plan:
- Reset then read all regs → rd_data = 0, rd_busy = 0, issue_ready = 1, sb_err = 0.
- Write r5 = 0xDEADBEEF on port 0 while reading r5 on port 1 in the same cycle → rd_data[1] = 0xDEADBEEF (bypass); next cycle stored read = 0xDEADBEEF. Write r0 = 0x1234 → r0 reads 0.
- Both write ports to r7 same cycle (p0 = 0x11, p1 = 0x22) → next-cycle read r7 = 0x22; bypass that cycle also shows 0x22.
- Issue with issue_wr to r3 three times (PEND_W = 2) → rd_busy for r3 = 1 and issue_ready drops on the 4th attempt. Retire to r3 the same cycle as the 4th attempt → issue_ready = 1, count stays 3. Three further retires → busy clears the same cycle as the last retire.
- Issue r9, then pipe_flush with a simultaneous issue to r9 → pend[r9] = 0, rd_busy = 0 next cycle.
- Retire r4 with pend = 0 → sb_err = 1 and it persists; assert flush_n mid-operation → everything returns to reset values asynchronously.
